// File: rtl/display_bcd_sequencer.sv
// Purpose: converts a 7-bit binary value to a formatted two-digit BCD word for the 7-segment driver.
// Latency: bcd_o/done_o update 8 edges after acceptance; the next accept is possible 9 edges after the previous one.
// Backpressure: ready_o is high only in IDLE; bin_i/valid_i are ignored while a conversion runs.
module display_bcd_sequencer #(
  parameter int MAX_VALUE          = 99,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] bin_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] bcd_o,
  output logic       done_o,
  output logic       ovf_o
);

  localparam int BIN_WIDTH = 7;
  localparam int SCR_WIDTH = 8 + BIN_WIDTH;
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VALUE);
  localparam logic [7:0] RESET_BCD = BLANK_LEADING_ZERO ? 8'hF0 : 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [SCR_WIDTH-1:0] scratch;
  logic [SCR_WIDTH-1:0] adj;
  logic [2:0]           count;
  logic                 ovf_pend;
  logic [3:0]           tens_fmt;

  // Accept new work only when idle and out of reset.
  assign ready_o = (state == IDLE) && rst_i;

  // Double-dabble correction: add 3 to each BCD nibble >= 5 before the shift.
  always_comb begin
    adj = scratch;
    if (scratch[10:7] >= 4'd5) adj[10:7] = scratch[10:7] + 4'd3;
    if (scratch[14:11] >= 4'd5) adj[14:11] = scratch[14:11] + 4'd3;
  end

  // Leading-zero blanking of the tens digit; units digit always shown.
  always_comb begin
    tens_fmt = scratch[14:11];
    if (BLANK_LEADING_ZERO && (scratch[14:11] == 4'd0)) tens_fmt = 4'hF;
  end

  // Conversion FSM: load in IDLE, 7 shift steps, then publish result in DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      scratch  <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
      bcd_o    <= RESET_BCD;
      done_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            scratch  <= {8'h00, bin_i};
            ovf_pend <= (bin_i > MAX_BIN);
            count    <= 3'd6;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[SCR_WIDTH-2:0], 1'b0};
          if (count == 3'd0) begin
            state <= DONE;
          end else begin
            count <= count - 3'd1;
          end
        end
        DONE: begin
          // Hundreds carry for 100..127 is dropped; overflow blanking covers it.
          if (ovf_pend) begin
            bcd_o <= 8'hFF;
            ovf_o <= 1'b1;
          end else begin
            bcd_o <= {tens_fmt, scratch[10:7]};
            ovf_o <= 1'b0;
          end
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/display_bcd_sequencer.md
Name: display_bcd_sequencer

Overview:
- Iterative binary-to-BCD controller that sequences updates into the two-digit multiplexed 7-segment driver.
- Accepts a 7-bit binary value (e.g. decoded Gray count) over a valid/ready handshake and converts it with a double-dabble FSM, one shift per clock.
- Formats the result (leading-zero blanking, overflow blanking) and holds a stable 8-bit BCD word for the driver's bcd_i.
- Sits between the decoder datapath and the display driver.

Parameters:
- MAX_VALUE, 99, largest value displayed; legal range 0..99; inputs above it produce overflow blanking.
- BLANK_LEADING_ZERO, 1, 1 = tens nibble forced to 4'hF (blank digit) when tens digit is 0; 0 = show leading zero.
- Width of the binary input is fixed at 7 (localparam BIN_WIDTH = 7).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous reset, active-low.
- bin_i  input  7  binary value to display, unsigned.
- valid_i  input  1  bin_i valid; a transfer occurs on a rising edge with valid_i && ready_o.
- ready_o  output  1  high only in IDLE and not in reset.
- bcd_o  output  8  {tens, units} BCD to driver; 4'hF nibble = blank digit.
- done_o  output  1  one-cycle pulse marking a bcd_o update.
- ovf_o  output  1  registered; high while bcd_o shows an overflow result.

Behaviour:
- Reset (rst_i low at a rising edge): state = IDLE, bcd_o = 8'hF0 if BLANK_LEADING_ZERO else 8'h00, done_o = 0, ovf_o = 0, shift counter = 0, scratch cleared.
- ready_o is combinational: (state == IDLE) && rst_i.
- Reset dominates every other condition in any state; a conversion in progress is aborted and its result discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: on an edge with valid_i && ready_o:
  - load scratch = {8'h00, bin_i};
  - latch ovf_pend = (bin_i > MAX_VALUE);
  - load counter = 6;
  - go to SHIFT.
- IDLE with valid_i low: hold state.
- SHIFT: each edge performs one double-dabble step on the 15-bit scratch:
  - add 3 to each BCD nibble that is >= 5;
  - then shift the whole scratch left by 1.
  - If counter == 0, go to DONE; else decrement counter.
  - Exactly 7 SHIFT edges are executed, regardless of value.
- DONE: one edge updates the outputs and returns to IDLE:
  - bcd_o <= 8'hFF and ovf_o <= 1 if ovf_pend;
  - otherwise bcd_o <= formatted BCD and ovf_o <= 0;
  - done_o <= 1.
- done_o is 0 on every other edge, so it is high for exactly one cycle.
- Formatting: tens nibble replaced by 4'hF when it is 0 and BLANK_LEADING_ZERO = 1; the units nibble is never blanked.
- Latency: with acceptance at edge A, bcd_o and done_o change at edge A+8. Minimum interval between accepts is 9 cycles; ready_o rises in the cycle after A+8.
- bin_i and valid_i are ignored outside IDLE. Changes on bin_i after acceptance have no effect.
- bcd_o is held constant between DONE updates; it never shows intermediate scratch values.
- Values 100..127: the hundreds carry is lost in the 8-bit BCD field, which is irrelevant because overflow forces 8'hFF.
- Inputs above MAX_VALUE but <= 99 (when MAX_VALUE < 99) also produce 8'hFF.
- valid_i held continuously high gives a repeated conversion every 9 cycles with a done_o pulse each time.

Test Plan:
- Reset, then bin_i = 42 with valid_i for 1 cycle -> ready_o low for 8 cycles; bcd_o = 8'h42, done_o one-cycle pulse at accept + 8 edges; ovf_o = 0.
- BLANK_LEADING_ZERO = 1: bin_i = 7 -> 8'hF7; bin_i = 0 -> 8'hF0; bin_i = 99 -> 8'h99. BLANK_LEADING_ZERO = 0: bin_i = 7 -> 8'h07.
- bin_i = 100 and bin_i = 127 -> bcd_o = 8'hFF, ovf_o = 1; next bin_i = 5 -> 8'hF5, ovf_o = 0.
- Accept 42, then at accept + 3 drive valid_i with bin_i = 13 and change bin_i -> request ignored; result 8'h42; 13 is converted only if valid_i is still high in IDLE.
- Accept 88, assert rst_i low at accept + 4 -> bcd_o = 8'hF0, no done_o pulse, ready_o = 1 after release; a new accept of 31 -> 8'h31.
- Sweep bin_i 0..127 back-to-back with valid_i high -> every result matches a reference model (tens/units or 8'hFF); exactly one done_o per accepted value, spaced 9 cycles apart.
